// File: rtl/apb_timer_evt_cond.sv
// Event conditioner and stop sequencer in front of the APB simple timer.
// Optional glitch-filter counter enabled by defining APB_TIMER_EVT_FILTER_EN.
module apb_timer_evt_cond #(
    parameter int NUM_EVT = 16,
    parameter int FILT_W  = 4
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [NUM_EVT-1:0]         evt_i,
    input  logic [$clog2(NUM_EVT)-1:0] cfg_lo_sel_i,
    input  logic [$clog2(NUM_EVT)-1:0] cfg_hi_sel_i,
    input  logic [1:0]                 cfg_lo_mode_i,
    input  logic [1:0]                 cfg_hi_mode_i,
    input  logic [FILT_W-1:0]          cfg_filt_len_i,
    output logic                       event_lo_o,
    output logic                       event_hi_o,
    input  logic                       stop_req_i,
    output logic                       stop_ack_o,
    output logic                       stoptimer_o,
    input  logic                       busy_i
);
    localparam int SEL_W = $clog2(NUM_EVT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STOPPING = 2'd1,
        ST_STOPPED  = 2'd2
    } stop_state_t;

    // Channel index 0 is the low channel, index 1 the high channel.
    logic [1:0][SEL_W-1:0] w_sel;
    logic [1:0][1:0]       w_mode;
    logic [1:0]            w_sel_chg;
    logic [1:0]            w_evt_new;
    logic [1:0]            w_strobe;
    logic [1:0]            w_hit;
    logic [1:0]            w_filt_nxt;
    logic [1:0][SEL_W-1:0] r_sel;
    logic [1:0]            r_evt_q;
    logic [1:0]            r_filt;
    logic [1:0]            r_pulse;
`ifdef APB_TIMER_EVT_FILTER_EN
    logic [1:0][FILT_W-1:0] r_cnt;
    logic [1:0][FILT_W-1:0] w_cnt_nxt;
`else
    logic                   w_unused_len;
    assign w_unused_len = ^cfg_filt_len_i;
`endif

    stop_state_t r_state;
    stop_state_t w_state_nxt;
    logic        r_stoptimer;
    logic        r_stop_ack;

    assign w_sel  = {cfg_hi_sel_i, cfg_lo_sel_i};
    assign w_mode = {cfg_hi_mode_i, cfg_lo_mode_i};

    // Per-channel filter decision and edge/mode qualification
    always_comb begin
        w_sel_chg  = 2'b00;
        w_evt_new  = 2'b00;
        w_strobe   = 2'b00;
        w_hit      = 2'b00;
        w_filt_nxt = r_filt;
`ifdef APB_TIMER_EVT_FILTER_EN
        w_cnt_nxt  = r_cnt;
`endif
        for (int c = 0; c < 2; c++) begin
            w_sel_chg[c] = (w_sel[c] != r_sel[c]);
            w_evt_new[c] = evt_i[w_sel[c]];
            // The new filtered level equals evt_q whenever the strobe fires.
            w_hit[c]     = r_evt_q[c] ? w_mode[c][0] : w_mode[c][1];
`ifdef APB_TIMER_EVT_FILTER_EN
            if (w_sel_chg[c]) begin
                w_filt_nxt[c] = w_evt_new[c];
                w_cnt_nxt[c]  = {FILT_W{1'b0}};
                w_strobe[c]   = 1'b0;
            end else if (r_evt_q[c] == r_filt[c]) begin
                w_filt_nxt[c] = r_filt[c];
                w_cnt_nxt[c]  = {FILT_W{1'b0}};
                w_strobe[c]   = 1'b0;
            end else if (r_cnt[c] >= cfg_filt_len_i) begin
                w_filt_nxt[c] = r_evt_q[c];
                w_cnt_nxt[c]  = {FILT_W{1'b0}};
                w_strobe[c]   = 1'b1;
            end else begin
                w_filt_nxt[c] = r_filt[c];
                w_cnt_nxt[c]  = r_cnt[c] + FILT_W'(1);
                w_strobe[c]   = 1'b0;
            end
`else
            if (w_sel_chg[c]) begin
                w_filt_nxt[c] = w_evt_new[c];
                w_strobe[c]   = 1'b0;
            end else begin
                w_filt_nxt[c] = r_evt_q[c];
                w_strobe[c]   = (r_evt_q[c] != r_filt[c]);
            end
`endif
        end
    end

    // Channel pipeline: sampled source, filtered level, counter and pulse
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sel   <= '0;
            r_evt_q <= 2'b00;
            r_filt  <= 2'b00;
            r_pulse <= 2'b00;
`ifdef APB_TIMER_EVT_FILTER_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_sel   <= w_sel;
            r_evt_q <= w_evt_new;
            r_filt  <= w_filt_nxt;
            r_pulse <= w_strobe & w_hit;
`ifdef APB_TIMER_EVT_FILTER_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign event_lo_o = r_pulse[0];
    assign event_hi_o = r_pulse[1];

    // Stop sequencer next state; STOPPING always lasts at least one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (stop_req_i) begin
                    w_state_nxt = ST_STOPPING;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_STOPPING: begin
                if (!stop_req_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (!busy_i) begin
                    w_state_nxt = ST_STOPPED;
                end else begin
                    w_state_nxt = ST_STOPPING;
                end
            end
            ST_STOPPED: begin
                if (!stop_req_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_STOPPED;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Stop sequencer state and outputs decoded from the next state
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_IDLE;
            r_stoptimer <= 1'b0;
            r_stop_ack  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_stoptimer <= (w_state_nxt != ST_IDLE);
            r_stop_ack  <= (w_state_nxt == ST_STOPPED);
        end
    end

    assign stoptimer_o = r_stoptimer;
    assign stop_ack_o  = r_stop_ack;

endmodule

// File: tb/tb_apb_timer_evt_cond.sv
// Bench for apb_timer_evt_cond: directed steps plus random traffic checked
// every cycle against a sample-timeline reference model.
module tb_apb_timer_evt_cond;
    localparam int NUM_EVT = 16;
    localparam int FILT_W  = 4;
    localparam int SEL_W   = $clog2(NUM_EVT);
    localparam int MAXC    = 8192;

    logic               HCLK = 1'b0;
    logic               HRESET;
    logic [NUM_EVT-1:0] evt_i;
    logic [SEL_W-1:0]   cfg_lo_sel_i;
    logic [SEL_W-1:0]   cfg_hi_sel_i;
    logic [1:0]         cfg_lo_mode_i;
    logic [1:0]         cfg_hi_mode_i;
    logic [FILT_W-1:0]  cfg_filt_len_i;
    logic               event_lo_o;
    logic               event_hi_o;
    logic               stop_req_i;
    logic               stop_ack_o;
    logic               stoptimer_o;
    logic               busy_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cnt_lo = 0;
    int cnt_hi = 0;
    int t = 0;

    // Reference model: every sampled value of each channel's selected line,
    // the accepted level, and the edge at which it was last (re)established.
    logic             m_samp [2][0:MAXC-1];
    logic             m_acc [2];
    int               m_last [2];
    logic [SEL_W-1:0] m_sel [2];
    logic             m_exp_pulse [2];
    int               m_req_run = 0;
    logic             m_ack_flag = 1'b0;

    apb_timer_evt_cond #(.NUM_EVT(NUM_EVT), .FILT_W(FILT_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .evt_i(evt_i),
        .cfg_lo_sel_i(cfg_lo_sel_i), .cfg_hi_sel_i(cfg_hi_sel_i),
        .cfg_lo_mode_i(cfg_lo_mode_i), .cfg_hi_mode_i(cfg_hi_mode_i),
        .cfg_filt_len_i(cfg_filt_len_i),
        .event_lo_o(event_lo_o), .event_hi_o(event_hi_o),
        .stop_req_i(stop_req_i), .stop_ack_o(stop_ack_o),
        .stoptimer_o(stoptimer_o), .busy_i(busy_i)
    );

    always #5 HCLK = ~HCLK;

    function automatic int eff_l(input logic [FILT_W-1:0] l);
`ifdef APB_TIMER_EVT_FILTER_EN
        return int'(l);
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply the rules to the inputs sampled at the current edge t.
    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            logic [SEL_W-1:0] sel_in;
            logic [1:0]       mode;
            logic             ok;
            int               l;
            sel_in = (c == 1) ? cfg_hi_sel_i : cfg_lo_sel_i;
            mode   = (c == 1) ? cfg_hi_mode_i : cfg_lo_mode_i;
            m_exp_pulse[c] = 1'b0;
            if (HRESET) begin
                m_acc[c]     = 1'b0;
                m_last[c]    = t;
                m_sel[c]     = '0;
                m_samp[c][t] = 1'b0;
            end else begin
                if (sel_in != m_sel[c]) begin
                    m_acc[c]  = evt_i[sel_in];
                    m_last[c] = t;
                end else begin
                    // Accept when the last L+1 samples since the previous
                    // acceptance all differ from the accepted level.
                    l  = eff_l(cfg_filt_len_i);
                    ok = 1'b1;
                    for (int i = 0; i <= l; i++) begin
                        int j;
                        j = t - 1 - i;
                        if (j < m_last[c] || m_samp[c][j] == m_acc[c]) ok = 1'b0;
                    end
                    if (ok) begin
                        m_acc[c]       = ~m_acc[c];
                        m_last[c]      = t;
                        m_exp_pulse[c] = m_acc[c] ? mode[0] : mode[1];
                    end
                end
                m_sel[c]     = sel_in;
                m_samp[c][t] = evt_i[sel_in];
            end
        end
        if (HRESET || !stop_req_i) begin
            m_req_run  = 0;
            m_ack_flag = 1'b0;
        end else begin
            m_req_run++;
            if (m_req_run >= 2 && !busy_i) m_ack_flag = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_edge();
        #1;
        check("event_lo", event_lo_o, m_exp_pulse[0]);
        check("event_hi", event_hi_o, m_exp_pulse[1]);
        check("stoptimer", stoptimer_o, m_req_run > 0);
        check("stop_ack", stop_ack_o, m_ack_flag);
        if (event_lo_o) cnt_lo++;
        if (event_hi_o) cnt_hi++;
        t++;
        if (t >= MAXC) begin
            $display("FAIL cycle_budget: observed %0d cycles expected fewer than %0d", t, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
    endtask

    initial begin
        int lat;
        HRESET = 1'b1; evt_i = '0; stop_req_i = 1'b0; busy_i = 1'b0;
        cfg_lo_sel_i = '0; cfg_hi_sel_i = '0; cfg_lo_mode_i = 2'b00;
        cfg_hi_mode_i = 2'b00; cfg_filt_len_i = 4'd0;
        tick(); tick();
        check("reset_lo", event_lo_o, 1'b0);
        check("reset_stop", stoptimer_o, 1'b0);
        HRESET = 1'b0;

        // L=3 rising on source 5: latency, then a 3-cycle glitch
        cfg_filt_len_i = 4'd3; cfg_lo_sel_i = 4'd5; cfg_lo_mode_i = 2'b01;
        repeat (6) tick();
        evt_i[5] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            tick();
            if (event_lo_o) lat = k - 1;
        end
        check_int("lo_rise_latency", lat, eff_l(4'd3) + 1);
        evt_i[5] = 1'b0;
        repeat (10) tick();
        cnt_lo = 0;
        evt_i[5] = 1'b1;
        repeat (3) tick();
        evt_i[5] = 1'b0;
        repeat (10) tick();
        check_int("glitch_pulses", cnt_lo, (eff_l(4'd3) >= 3) ? 0 : 1);

        // L=0, both edges on source 2: six toggles give six pulses
        cfg_filt_len_i = 4'd0; cfg_hi_sel_i = 4'd2; cfg_hi_mode_i = 2'b11;
        repeat (4) tick();
        cnt_hi = 0;
        for (int k = 0; k < 6; k++) begin
            evt_i[2] = ~evt_i[2];
            repeat (4) tick();
        end
        check_int("toggle_pulses", cnt_hi, 6);

        // Shared source 7, L=1: lo on rise, hi on fall
        cfg_filt_len_i = 4'd1; cfg_lo_sel_i = 4'd7; cfg_hi_sel_i = 4'd7;
        cfg_lo_mode_i = 2'b01; cfg_hi_mode_i = 2'b10;
        repeat (5) tick();
        cnt_lo = 0; cnt_hi = 0;
        evt_i[7] = 1'b1;
        repeat (10) tick();
        evt_i[7] = 1'b0;
        repeat (8) tick();
        check_int("shared_lo", cnt_lo, 1);
        check_int("shared_hi", cnt_hi, 1);

        // Select switch between differing sources gives no pulse
        cfg_lo_sel_i = 4'd0; cfg_lo_mode_i = 2'b11; cfg_hi_mode_i = 2'b00;
        evt_i[0] = 1'b0; evt_i[1] = 1'b1;
        repeat (6) tick();
        cnt_lo = 0;
        cfg_lo_sel_i = 4'd1;
        repeat (8) tick();
        check_int("sel_switch", cnt_lo, 0);

        // Stop handshake with busy held for five cycles
        busy_i = 1'b1; stop_req_i = 1'b1;
        tick();
        check("stop_cmd_rise", stoptimer_o, 1'b1);
        repeat (4) tick();
        check("no_ack_busy", stop_ack_o, 1'b0);
        busy_i = 1'b0;
        tick();
        check("ack_after_busy", stop_ack_o, 1'b1);
        stop_req_i = 1'b0;
        tick();
        check("release_stop", stoptimer_o, 1'b0);
        // Abort while stopping
        busy_i = 1'b1; stop_req_i = 1'b1;
        repeat (2) tick();
        stop_req_i = 1'b0;
        tick();
        check("abort_stop", stoptimer_o, 1'b0);
        check("abort_ack", stop_ack_o, 1'b0);
        // Reset while stopped
        busy_i = 1'b0; stop_req_i = 1'b1;
        repeat (3) tick();
        HRESET = 1'b1;
        tick();
        check("rst_stopped_ack", stop_ack_o, 1'b0);
        HRESET = 1'b0; stop_req_i = 1'b0;
        tick();

        // Random traffic against the model
        for (int seg = 0; seg < 5; seg++) begin
            cfg_filt_len_i = FILT_W'($urandom_range(0, 3));
            cfg_lo_sel_i   = SEL_W'($urandom_range(0, NUM_EVT - 1));
            cfg_hi_sel_i   = SEL_W'($urandom_range(0, NUM_EVT - 1));
            cfg_lo_mode_i  = 2'($urandom_range(0, 3));
            cfg_hi_mode_i  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 350; k++) begin
                tick();
                if (seg[0]) evt_i = evt_i ^ NUM_EVT'($urandom & $urandom & $urandom);
                else        evt_i = evt_i ^ NUM_EVT'($urandom & $urandom & $urandom & $urandom);
                if ($urandom_range(0, 49) == 0) cfg_lo_sel_i = SEL_W'($urandom_range(0, NUM_EVT - 1));
                if ($urandom_range(0, 49) == 0) cfg_hi_sel_i = SEL_W'($urandom_range(0, NUM_EVT - 1));
                if ($urandom_range(0, 99) == 0) cfg_filt_len_i = FILT_W'($urandom_range(0, 4));
                if ($urandom_range(0, 7) == 0) stop_req_i = ~stop_req_i;
                busy_i  = ($urandom_range(0, 2) != 0);
                HRESET  = ($urandom_range(0, 299) == 0);
            end
            HRESET = 1'b0;
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
